// File: rtl/gpu_cmd_reader.sv
// Command FIFO consumer: pops 82-bit entries, decodes, range-checks and normalises them,
// then presents one command at a time to the raster engine. Optional stats: GPU_CMD_RDR_STATS_EN.
module gpu_cmd_reader #(
    parameter int unsigned MAX_X = 639,
    parameter int unsigned MAX_Y = 479
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fifo_empty,
    input  logic        fifo_w_busy,
    input  logic [81:0] fifo_r_data,
    output logic        fifo_r_enable,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [3:0]  cmd_op,
    output logic [9:0]  cmd_x0,
    output logic [9:0]  cmd_y0,
    output logic [9:0]  cmd_x1,
    output logic [9:0]  cmd_y1,
    output logic [23:0] cmd_color,
    output logic [13:0] cmd_aux,
    output logic        err_pulse
`ifdef GPU_CMD_RDR_STATS_EN
    ,
    output logic [15:0] cmd_count,
    output logic [7:0]  err_count
`endif
);

    localparam int unsigned OP_W   = 4;
    localparam int unsigned CRD_W  = 10;
    localparam int unsigned COL_W  = 24;
    localparam int unsigned AUX_W  = 14;

    localparam logic [CRD_W-1:0] MAX_X_C = CRD_W'(MAX_X);
    localparam logic [CRD_W-1:0] MAX_Y_C = CRD_W'(MAX_Y);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_POP  = 2'd1;
    localparam logic [1:0] S_LOAD = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    localparam logic [OP_W-1:0] OP_NOP   = 4'd0;
    localparam logic [OP_W-1:0] OP_LINE  = 4'd1;
    localparam logic [OP_W-1:0] OP_RECT  = 4'd2;
    localparam logic [OP_W-1:0] OP_FILL  = 4'd3;
    localparam logic [OP_W-1:0] OP_CLEAR = 4'd4;

    logic [1:0]       state_q, state_d;
    logic             fifo_r_enable_q, fifo_r_enable_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic             err_pulse_q, err_pulse_d;
    logic [OP_W-1:0]  cmd_op_q, cmd_op_d;
    logic [CRD_W-1:0] cmd_x0_q, cmd_x0_d, cmd_y0_q, cmd_y0_d;
    logic [CRD_W-1:0] cmd_x1_q, cmd_x1_d, cmd_y1_q, cmd_y1_d;
    logic [COL_W-1:0] cmd_color_q, cmd_color_d;
    logic [AUX_W-1:0] cmd_aux_q, cmd_aux_d;

    logic [OP_W-1:0]  in_op;
    logic [CRD_W-1:0] in_x0, in_y0, in_x1, in_y1;
    logic [CRD_W-1:0] nx0, ny0, nx1, ny1;
    logic             is_draw, range_bad, load_err;

    // Field extraction, legality check and corner normalisation of the FIFO word.
    always_comb begin
        in_op     = fifo_r_data[81:78];
        in_x0     = fifo_r_data[77:68];
        in_y0     = fifo_r_data[67:58];
        in_x1     = fifo_r_data[57:48];
        in_y1     = fifo_r_data[47:38];
        is_draw   = (in_op == OP_LINE) || (in_op == OP_RECT) || (in_op == OP_FILL);
        range_bad = (in_x0 > MAX_X_C) || (in_x1 > MAX_X_C) ||
                    (in_y0 > MAX_Y_C) || (in_y1 > MAX_Y_C);
        load_err  = (in_op > OP_CLEAR) || (is_draw && range_bad);
        nx0 = in_x0;
        ny0 = in_y0;
        nx1 = in_x1;
        ny1 = in_y1;
        if ((in_op == OP_RECT) || (in_op == OP_FILL)) begin
            if (in_x0 > in_x1) begin
                nx0 = in_x1;
                nx1 = in_x0;
            end
            if (in_y0 > in_y1) begin
                ny0 = in_y1;
                ny1 = in_y0;
            end
        end else if (in_op == OP_CLEAR) begin
            nx0 = '0;
            ny0 = '0;
            nx1 = '0;
            ny1 = '0;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d         = state_q;
        fifo_r_enable_d = 1'b0;
        cmd_valid_d     = cmd_valid_q;
        err_pulse_d     = 1'b0;
        cmd_op_d        = cmd_op_q;
        cmd_x0_d        = cmd_x0_q;
        cmd_y0_d        = cmd_y0_q;
        cmd_x1_d        = cmd_x1_q;
        cmd_y1_d        = cmd_y1_q;
        cmd_color_d     = cmd_color_q;
        cmd_aux_d       = cmd_aux_q;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty && !fifo_w_busy) begin
                    state_d         = S_POP;
                    fifo_r_enable_d = 1'b1;
                end
            end
            S_POP: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                if (load_err) begin
                    err_pulse_d = 1'b1;
                    state_d     = S_IDLE;
                end else if (in_op == OP_NOP) begin
                    state_d = S_IDLE;
                end else begin
                    cmd_op_d    = in_op;
                    cmd_x0_d    = nx0;
                    cmd_y0_d    = ny0;
                    cmd_x1_d    = nx1;
                    cmd_y1_d    = ny1;
                    cmd_color_d = fifo_r_data[37:14];
                    cmd_aux_d   = fifo_r_data[13:0];
                    cmd_valid_d = 1'b1;
                    state_d     = S_OUT;
                end
            end
            S_OUT: begin
                if (cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                cmd_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            fifo_r_enable_q <= 1'b0;
            cmd_valid_q     <= 1'b0;
            err_pulse_q     <= 1'b0;
            cmd_op_q        <= '0;
            cmd_x0_q        <= '0;
            cmd_y0_q        <= '0;
            cmd_x1_q        <= '0;
            cmd_y1_q        <= '0;
            cmd_color_q     <= '0;
            cmd_aux_q       <= '0;
        end else begin
            state_q         <= state_d;
            fifo_r_enable_q <= fifo_r_enable_d;
            cmd_valid_q     <= cmd_valid_d;
            err_pulse_q     <= err_pulse_d;
            cmd_op_q        <= cmd_op_d;
            cmd_x0_q        <= cmd_x0_d;
            cmd_y0_q        <= cmd_y0_d;
            cmd_x1_q        <= cmd_x1_d;
            cmd_y1_q        <= cmd_y1_d;
            cmd_color_q     <= cmd_color_d;
            cmd_aux_q       <= cmd_aux_d;
        end
    end

    assign fifo_r_enable = fifo_r_enable_q;
    assign cmd_valid     = cmd_valid_q;
    assign err_pulse     = err_pulse_q;
    assign cmd_op        = cmd_op_q;
    assign cmd_x0        = cmd_x0_q;
    assign cmd_y0        = cmd_y0_q;
    assign cmd_x1        = cmd_x1_q;
    assign cmd_y1        = cmd_y1_q;
    assign cmd_color     = cmd_color_q;
    assign cmd_aux       = cmd_aux_q;

`ifdef GPU_CMD_RDR_STATS_EN
    logic [15:0] cmd_count_q, cmd_count_d;
    logic [7:0]  err_count_q, err_count_d;

    // Handshake counter wraps; error counter saturates and moves with the pulse itself.
    always_comb begin
        cmd_count_d = cmd_count_q;
        err_count_d = err_count_q;
        if (cmd_valid_q && cmd_ready) begin
            cmd_count_d = cmd_count_q + 16'd1;
        end
        if (err_pulse_d && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_count_q <= '0;
            err_count_q <= '0;
        end else begin
            cmd_count_q <= cmd_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign cmd_count = cmd_count_q;
    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_gpu_cmd_reader.sv
// Bench for gpu_cmd_reader: FIFO model, directed corner cases and randomized traffic
// scored against a queue-based reference of the decode/normalise rules.
module tb_gpu_cmd_reader;

    logic        clk;
    logic        rst;
    logic        fifo_empty;
    logic        fifo_w_busy;
    logic [81:0] fifo_r_data;
    logic        fifo_r_enable;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [9:0]  cmd_x0, cmd_y0, cmd_x1, cmd_y1;
    logic [23:0] cmd_color;
    logic [13:0] cmd_aux;
    logic        err_pulse;
`ifdef GPU_CMD_RDR_STATS_EN
    logic [15:0] cmd_count;
    logic [7:0]  err_count;
`endif

    gpu_cmd_reader dut (
        .clk           (clk),
        .rst           (rst),
        .fifo_empty    (fifo_empty),
        .fifo_w_busy   (fifo_w_busy),
        .fifo_r_data   (fifo_r_data),
        .fifo_r_enable (fifo_r_enable),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_x0        (cmd_x0),
        .cmd_y0        (cmd_y0),
        .cmd_x1        (cmd_x1),
        .cmd_y1        (cmd_y1),
        .cmd_color     (cmd_color),
        .cmd_aux       (cmd_aux),
        .err_pulse     (err_pulse)
`ifdef GPU_CMD_RDR_STATS_EN
        ,
        .cmd_count     (cmd_count),
        .err_count     (err_count)
`endif
    );

    int checks = 0;
    int errors = 0;

    logic [81:0] fifo_q[$];
    logic [81:0] exp_q[$];
    int exp_cmd_n   = 0;
    int exp_err_n   = 0;
    int exp_err_all = 0;
    int err_seen    = 0;
    int valid_rises = 0;
    int hs_count    = 0;
    logic rand_ready = 1'b0;
    logic dir_ready  = 1'b1;

    task automatic check(input string tag, input logic [81:0] got, input logic [81:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // FIFO read side: data registered on a pop, empty flag registered; pop dropped on a push.
    initial fifo_empty = 1'b1;
    initial fifo_r_data = '0;
    always @(posedge clk) begin
        if (fifo_r_enable && !fifo_w_busy && fifo_q.size() > 0)
            fifo_r_data <= fifo_q.pop_front();
        fifo_empty <= (fifo_q.size() == 0);
    end

    initial begin
        cmd_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cmd_ready = rand_ready ? 1'($urandom_range(0, 1)) : dir_ready;
        end
    end

    // Reference: what a FIFO entry should become at the raster interface.
    task automatic model(input logic [81:0] e);
        int op, x0, y0, x1, y1;
        op = int'(e[81:78]);
        x0 = int'(e[77:68]);
        y0 = int'(e[67:58]);
        x1 = int'(e[57:48]);
        y1 = int'(e[47:38]);
        if (op > 4) begin
            exp_err_n++;
            exp_err_all++;
        end else if (op == 0) begin
        end else if (op == 4) begin
            exp_q.push_back({4'd4, 40'd0, e[37:0]});
            exp_cmd_n++;
        end else if (x0 > 639 || x1 > 639 || y0 > 479 || y1 > 479) begin
            exp_err_n++;
            exp_err_all++;
        end else if (op == 1) begin
            exp_q.push_back(e);
            exp_cmd_n++;
        end else begin
            exp_q.push_back({e[81:78],
                             10'((x0 < x1) ? x0 : x1), 10'((y0 < y1) ? y0 : y1),
                             10'((x0 > x1) ? x0 : x1), 10'((y0 > y1) ? y0 : y1),
                             e[37:0]});
            exp_cmd_n++;
        end
    endtask

    task automatic push(input logic [81:0] e);
        fifo_q.push_back(e);
        model(e);
    endtask

    function automatic logic [81:0] rand_entry();
        logic [3:0] op;
        logic [9:0] x0, y0, x1, y1;
        int r;
        r = int'($urandom_range(0, 15));
        op = (r < 12) ? 4'(r % 5) : 4'($urandom_range(5, 15));
        x0 = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(640, 1023)) : 10'($urandom_range(0, 639));
        x1 = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(640, 1023)) : 10'($urandom_range(0, 639));
        y0 = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(480, 1023)) : 10'($urandom_range(0, 479));
        y1 = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(480, 1023)) : 10'($urandom_range(0, 479));
        return {op, x0, y0, x1, y1, 24'($urandom), 14'($urandom)};
    endfunction

    // Interface monitor: pop width, field stability, handshakes scored against the reference.
    logic [81:0] cur, prev_fields;
    logic prev_valid = 1'b0, prev_ready = 1'b0, prev_ren = 1'b0;
    always @(negedge clk) begin
        cur = {cmd_op, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, cmd_aux};
        if (rst) begin
            prev_valid = 1'b0;
            prev_ren   = 1'b0;
        end else begin
            if (fifo_r_enable) check("pop_one_cycle", prev_ren, 0);
            if (err_pulse) err_seen++;
            if (cmd_valid && !prev_valid) valid_rises++;
            if (cmd_valid && prev_valid && !prev_ready) check("hold_stable", cur, prev_fields);
            if (cmd_valid && cmd_ready) begin
                hs_count++;
                check("cmd_expected", 82'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) check("cmd_fields", cur, exp_q.pop_front());
            end
            prev_valid  = cmd_valid;
            prev_ready  = cmd_ready;
            prev_fields = cur;
            prev_ren    = fifo_r_enable;
        end
    end

    task automatic drain(input string tag);
        int t;
        t = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0 || cmd_valid) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        repeat (5) @(negedge clk);
        check(tag, 82'(t < 2000), 1);
    endtask

    initial begin
        int base_err, base_rise, base_hs, pop_at, valid_at, vcnt, t;
        rst         = 1'b1;
        fifo_w_busy = 1'b0;

        // Reset with a non-empty FIFO (holding a NOP).
        push({4'd0, 78'd0});
        repeat (3) @(negedge clk);
        check("rst_fifo_empty_low", fifo_empty, 0);
        check("rst_r_enable", fifo_r_enable, 0);
        check("rst_valid", cmd_valid, 0);
        check("rst_err", err_pulse, 0);
        check("rst_fields", {cmd_op, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, cmd_aux}, 0);
        exp_cmd_n = 0;
        exp_err_n = 0;
        rst = 1'b0;
        drain("drain_nop");
        check("nop_no_valid", valid_rises, 0);
        check("nop_no_err", err_seen, 0);

        // LINE: latency and pass-through of unordered endpoints.
        pop_at = -1;
        valid_at = -1;
        vcnt = 0;
        push({4'd1, 10'd10, 10'd20, 10'd5, 10'd7, 24'hFF0000, 14'd0});
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (fifo_r_enable && pop_at < 0) pop_at = k;
            if (cmd_valid) begin
                vcnt++;
                if (valid_at < 0) begin
                    valid_at = k;
                    check("line_fields", {cmd_op, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, cmd_aux},
                          {4'd1, 10'd10, 10'd20, 10'd5, 10'd7, 24'hFF0000, 14'd0});
                end
            end
        end
        check("line_pop_latency", 82'(pop_at), 2);
        check("line_valid_latency", 82'(valid_at), 4);
        check("line_valid_width", 82'(vcnt), 1);
        drain("drain_line");

        // RECT with ready held low: swapped corners, stable fields, single handshake.
        dir_ready = 1'b0;
        repeat (2) @(negedge clk);
        base_hs = hs_count;
        push({4'd2, 10'd300, 10'd200, 10'd100, 10'd50, 24'h00FF00, 14'd5});
        t = 0;
        while (!cmd_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        for (int i = 0; i < 5; i++) begin
            check("rect_valid", cmd_valid, 1);
            check("rect_fields", {cmd_op, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, cmd_aux},
                  {4'd2, 10'd100, 10'd50, 10'd300, 10'd200, 24'h00FF00, 14'd5});
            if (i < 4) @(negedge clk);
        end
        dir_ready = 1'b1;
        drain("drain_rect");
        check("rect_single_hs", 82'(hs_count - base_hs), 1);

        // Illegal opcode, out-of-range LINE, then NOP.
        base_err  = err_seen;
        base_rise = valid_rises;
        push({4'd7, 78'd0});
        push({4'd1, 10'd1, 10'd2, 10'd640, 10'd3, 24'h123456, 14'd9});
        push({4'd0, 78'd0});
        drain("drain_err");
        check("err_pulses", 82'(err_seen - base_err), 2);
        check("err_no_valid", 82'(valid_rises - base_rise), 0);

        // Write-busy holds off the pop; CLEAR zeroes coordinates.
        fifo_w_busy = 1'b1;
        push({4'd4, 10'd9, 10'd9, 10'd9, 10'd9, 24'hABCDEF, 14'd77});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("busy_no_pop", fifo_r_enable, 0);
        end
        fifo_w_busy = 1'b0;
        @(negedge clk);
        check("busy_release_pop", fifo_r_enable, 1);
        drain("drain_clear");

        // Reset while in LOAD: entry lost, nothing presented.
        base_rise = valid_rises;
        fifo_q.push_back({4'd1, 10'd1, 10'd1, 10'd2, 10'd2, 24'h1, 14'd1});
        t = 0;
        while (!fifo_r_enable && t < 20) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        rst = 1'b1;
        exp_cmd_n = 0;
        exp_err_n = 0;
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("rst_load_no_valid", 82'(valid_rises - base_rise), 0);
        check("rst_load_fields", {cmd_op, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, cmd_aux}, 0);
`ifdef GPU_CMD_RDR_STATS_EN
        check("rst_load_cmd_count", cmd_count, 0);
`endif

        // Randomized traffic with random back-pressure.
        rand_ready = 1'b1;
        for (int n = 0; n < 120; n++) begin
            push(rand_entry());
            if ($urandom_range(0, 3) == 0) push(rand_entry());
            repeat ($urandom_range(0, 6)) @(negedge clk);
        end
        drain("drain_random");
        rand_ready = 1'b0;
        check("leftover_expected", 82'(exp_q.size()), 0);
        check("err_total", 82'(err_seen), 82'(exp_err_all));
`ifdef GPU_CMD_RDR_STATS_EN
        check("cmd_count", cmd_count, 82'(16'(exp_cmd_n)));
        check("err_count", err_count, 82'((exp_err_n > 255) ? 255 : exp_err_n));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
